lk_route_info_buffer: RTL and testbench

Per-input-port storage for look-ahead routing results, one small packet-granular FIFO per virtual channel. It sits directly downstream of `look_ahead_routing`. On each head-flit write it captures the look-ahead destination port and destination endpoint address. It holds them until that packet's tail flit leaves the input buffer, then presents the next queued packet's route to the VC/switch allocators.

---
 rtl/lk_route_info_buffer_pkg.sv | 35 +++
 rtl/lk_route_info_buffer_route_info_fifo.sv | 100 ++++++++++
 rtl/lk_route_info_buffer.sv | 79 +++++++
 tb/tb_lk_route_info_buffer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lk_route_info_buffer_pkg.sv
// Shared NoC helpers for the look-ahead route info buffer.
// Provides:
//   log2      - ceiling log2, returns at least 1 so that widths stay legal
//   entry_w   - per-VC route entry width (destport + endpoint address)
//   slice_lo  - low bit of VC slice idx in a packed per-VC bus
//   slice_hi  - high bit of VC slice idx in a packed per-VC bus
package lk_route_info_buffer_pkg;

  localparam int unsigned LK_DSTPW_DEFAULT = 4;
  localparam int unsigned LK_EAW_DEFAULT   = 3;
  localparam int unsigned LK_ENTRY_W       = LK_DSTPW_DEFAULT + LK_EAW_DEFAULT;

  function automatic int unsigned log2(input int unsigned n);
    for (int unsigned r = 1; r < 32; r++) begin
      if ((32'd1 << r) >= n) return r;
    end
    return 32;
  endfunction

  function automatic int unsigned entry_w(input int unsigned dstpw,
                                          input int unsigned eaw);
    return dstpw + eaw;
  endfunction

  function automatic int unsigned slice_lo(input int unsigned idx,
                                           input int unsigned w);
    return idx * w;
  endfunction

  function automatic int unsigned slice_hi(input int unsigned idx,
                                           input int unsigned w);
    return (idx + 1) * w - 1;
  endfunction

endpackage

// File: rtl/lk_route_info_buffer_route_info_fifo.sv
// route_info_fifo: one per-VC circular FIFO of look-ahead route entries.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   push                - head flit written to this VC
//   pop_req             - tail flit leaving this VC (ignored when empty)
//   wr_destport         - destport of the head flit being pushed
//   wr_dest_e_addr      - endpoint address of the head flit being pushed
//   route_valid         - at least one entry stored
//   full                - PKT_NUM entries stored
//   destport            - head entry destport (0 when empty)
//   dest_e_addr         - head entry endpoint address (0 when empty)
//   err_pulse           - dropped push or empty pop this cycle
// Optional feature macro: LK_ROUTE_BYPASS_EN (push to an empty FIFO is
// visible on the outputs in the same cycle).
module route_info_fifo
  import lk_route_info_buffer_pkg::*;
#(
  parameter int unsigned DSTPw   = 4,
  parameter int unsigned EAw     = 3,
  parameter int unsigned PKT_NUM = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop_req,
  input  logic [DSTPw-1:0] wr_destport,
  input  logic [EAw-1:0]   wr_dest_e_addr,
  output logic             route_valid,
  output logic             full,
  output logic [DSTPw-1:0] destport,
  output logic [EAw-1:0]   dest_e_addr,
  output logic             err_pulse
);

  localparam int unsigned EW = entry_w(DSTPw, EAw);
  localparam int unsigned PW = log2(PKT_NUM);
  localparam int unsigned CW = log2(PKT_NUM + 1);

  logic [EW-1:0] mem [PKT_NUM];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt;

  logic          empty;
  logic          is_full;
  logic          pop;
  logic          push_ok;
  logic [EW-1:0] head;

  // Pointers wrap naturally at PKT_NUM (power of two); a single-entry FIFO
  // keeps both pointers pinned at 0.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (PKT_NUM == 1) return '0;
    return p + 1'b1;
  endfunction

  always_comb begin
    empty     = (cnt == '0);
    is_full   = (cnt == CW'(PKT_NUM));
    pop       = pop_req & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_ok   = push & (~is_full | pop);
    err_pulse = (push & ~push_ok) | (pop_req & empty);
    head      = mem[rptr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) begin
        mem[wptr] <= {wr_destport, wr_dest_e_addr};
        wptr      <= ptr_inc(wptr);
      end
      if (pop) rptr <= ptr_inc(rptr);
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_comb begin
    full        = is_full;
    route_valid = ~empty;
    destport    = empty ? '0 : head[EW-1:EAw];
    dest_e_addr = empty ? '0 : head[EAw-1:0];
`ifdef LK_ROUTE_BYPASS_EN
    if (empty & push) begin
      route_valid = 1'b1;
      destport    = wr_destport;
      dest_e_addr = wr_dest_e_addr;
    end
`endif
  end

endmodule

// File: rtl/lk_route_info_buffer.sv
// lk_route_info_buffer: per-input-port storage of look-ahead routing results,
// one packet-granular route FIFO per VC.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   wr_en            - head flit written this cycle
//   wr_vc_num        - one-hot VC of the head flit
//   wr_destport      - look-ahead destination port of the head flit
//   wr_dest_e_addr   - destination endpoint address of the head flit
//   rd_tail          - tail flit leaving the input buffer this cycle
//   rd_vc_num        - one-hot VC of the departing tail flit
//   route_valid      - per VC: at least one stored route
//   destport_o       - per VC head destport, VC i at [(i+1)*DSTPw-1 : i*DSTPw]
//   dest_e_addr_o    - per VC head endpoint address, same packing
//   full             - per VC: PKT_NUM routes stored
//   err              - sticky: dropped write or empty pop seen since reset
// Optional feature macro: LK_ROUTE_BYPASS_EN.
module lk_route_info_buffer
  import lk_route_info_buffer_pkg::*;
#(
  parameter int unsigned V       = 4,
  parameter int unsigned DSTPw   = 4,
  parameter int unsigned EAw     = 3,
  parameter int unsigned PKT_NUM = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [V-1:0]       wr_vc_num,
  input  logic [DSTPw-1:0]   wr_destport,
  input  logic [EAw-1:0]     wr_dest_e_addr,
  input  logic               rd_tail,
  input  logic [V-1:0]       rd_vc_num,
  output logic [V-1:0]       route_valid,
  output logic [V*DSTPw-1:0] destport_o,
  output logic [V*EAw-1:0]   dest_e_addr_o,
  output logic [V-1:0]       full,
  output logic               err
);

  logic [V-1:0] err_pulse;

  for (genvar i = 0; i < V; i++) begin : g_vc
    route_info_fifo #(
      .DSTPw  (DSTPw),
      .EAw    (EAw),
      .PKT_NUM(PKT_NUM)
    ) u_fifo (
      .clk           (clk),
      .reset         (reset),
      .push          (wr_en & wr_vc_num[i]),
      .pop_req       (rd_tail & rd_vc_num[i]),
      .wr_destport   (wr_destport),
      .wr_dest_e_addr(wr_dest_e_addr),
      .route_valid   (route_valid[i]),
      .full          (full[i]),
      .destport      (destport_o[slice_hi(i, DSTPw):slice_lo(i, DSTPw)]),
      .dest_e_addr   (dest_e_addr_o[slice_hi(i, EAw):slice_lo(i, EAw)]),
      .err_pulse     (err_pulse[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (|err_pulse) begin
      err <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  a_wr_onehot : assert property (@(posedge clk) disable iff (reset)
    wr_en |-> $onehot0(wr_vc_num))
    else $error("lk_route_info_buffer: multi-hot wr_vc_num");
  a_rd_onehot : assert property (@(posedge clk) disable iff (reset)
    rd_tail |-> $onehot0(rd_vc_num))
    else $error("lk_route_info_buffer: multi-hot rd_vc_num");
`endif

endmodule

// File: tb/tb_lk_route_info_buffer.sv
// Self-checking bench for lk_route_info_buffer (V=4, DSTPw=4, EAw=3,
// PKT_NUM=2). A per-VC reference queue is filled when pushes are driven and
// drained when pops are driven; DUT heads are compared against queue fronts.
module tb_lk_route_info_buffer;

  localparam int V       = 4;
  localparam int DSTPw   = 4;
  localparam int EAw     = 3;
  localparam int PKT_NUM = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               wr_en;
  logic [V-1:0]       wr_vc_num;
  logic [DSTPw-1:0]   wr_destport;
  logic [EAw-1:0]     wr_dest_e_addr;
  logic               rd_tail;
  logic [V-1:0]       rd_vc_num;
  logic [V-1:0]       route_valid;
  logic [V*DSTPw-1:0] destport_o;
  logic [V*EAw-1:0]   dest_e_addr_o;
  logic [V-1:0]       full;
  logic               err;

  lk_route_info_buffer #(
    .V      (V),
    .DSTPw  (DSTPw),
    .EAw    (EAw),
    .PKT_NUM(PKT_NUM)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_vc_num     (wr_vc_num),
    .wr_destport   (wr_destport),
    .wr_dest_e_addr(wr_dest_e_addr),
    .rd_tail       (rd_tail),
    .rd_vc_num     (rd_vc_num),
    .route_valid   (route_valid),
    .destport_o    (destport_o),
    .dest_e_addr_o (dest_e_addr_o),
    .full          (full),
    .err           (err)
  );

  always #5 clk = ~clk;

  logic [DSTPw+EAw-1:0] mq [V][$];
  logic                 m_err;
  int                   n_checks = 0;
  int                   n_fail   = 0;

  function automatic logic [V-1:0] exp_valid();
    logic [V-1:0] r = '0;
    for (int v = 0; v < V; v++) r[v] = (mq[v].size() != 0);
    return r;
  endfunction

  function automatic logic [V-1:0] exp_full();
    logic [V-1:0] r = '0;
    for (int v = 0; v < V; v++) r[v] = (mq[v].size() == PKT_NUM);
    return r;
  endfunction

  function automatic logic [V*DSTPw-1:0] exp_dp();
    logic [V*DSTPw-1:0] r = '0;
    for (int v = 0; v < V; v++) begin
      if (mq[v].size() != 0) begin
        logic [DSTPw+EAw-1:0] e = mq[v][0];
        r[v*DSTPw +: DSTPw] = e[DSTPw+EAw-1:EAw];
      end
    end
    return r;
  endfunction

  function automatic logic [V*EAw-1:0] exp_ea();
    logic [V*EAw-1:0] r = '0;
    for (int v = 0; v < V; v++) begin
      if (mq[v].size() != 0) begin
        logic [DSTPw+EAw-1:0] e = mq[v][0];
        r[v*EAw +: EAw] = e[EAw-1:0];
      end
    end
    return r;
  endfunction

  task automatic idle_inputs();
    wr_en          = 1'b0;
    wr_vc_num      = '0;
    wr_destport    = '0;
    wr_dest_e_addr = '0;
    rd_tail        = 1'b0;
    rd_vc_num      = '0;
  endtask

  // One clock of stimulus; the reference queues follow the driven intent.
  task automatic step(input bit we, input int wvc, input logic [DSTPw-1:0] dp,
                      input logic [EAw-1:0] ea, input bit rt, input int rvc);
    bit popok;
    bit pushok;
    wr_en          = we;
    wr_vc_num      = we ? V'(1 << wvc) : '0;
    wr_destport    = dp;
    wr_dest_e_addr = ea;
    rd_tail        = rt;
    rd_vc_num      = rt ? V'(1 << rvc) : '0;
    @(posedge clk);
    #1;
    idle_inputs();
    popok  = rt && (mq[rvc].size() != 0);
    pushok = we && ((mq[wvc].size() < PKT_NUM) || (popok && rvc == wvc));
    if (we && !pushok) m_err = 1'b1;
    if (rt && mq[rvc].size() == 0) m_err = 1'b1;
    if (popok) void'(mq[rvc].pop_front());
    if (pushok) mq[wvc].push_back({dp, ea});
  endtask

  task automatic do_reset(input bit with_push);
    reset = 1'b1;
    if (with_push) begin
      wr_en          = 1'b1;
      wr_vc_num      = 4'b0001;
      wr_destport    = 4'hF;
      wr_dest_e_addr = 3'd7;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();
    for (int v = 0; v < V; v++) mq[v].delete();
    m_err = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    n_checks++;
    if (route_valid !== '0) begin
      n_fail++; $display("FAIL reset_rv: got %b expected 0", route_valid);
    end
    n_checks++;
    if (full !== '0) begin
      n_fail++; $display("FAIL reset_full: got %b expected 0", full);
    end
    n_checks++;
    if (destport_o !== '0 || dest_e_addr_o !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h expected 0/0", destport_o, dest_e_addr_o);
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL reset_err: got %b expected 0", err);
    end
  endtask

  task automatic test_single_push();
    do_reset(1'b0);
    step(1, 2, 4'b0101, 3'd6, 0, 0);
    n_checks++;
    if (route_valid !== 4'b0100) begin
      n_fail++; $display("FAIL push_rv: got %b expected 0100", route_valid);
    end
    n_checks++;
    if (destport_o !== 16'h0500 || destport_o !== exp_dp()) begin
      n_fail++; $display("FAIL push_dp: got %h expected 0500", destport_o);
    end
    n_checks++;
    if (dest_e_addr_o !== 12'h180 || dest_e_addr_o !== exp_ea()) begin
      n_fail++; $display("FAIL push_ea: got %h expected 180", dest_e_addr_o);
    end
  endtask

  task automatic test_fill_drain();
    do_reset(1'b0);
    step(1, 0, 4'hA, 3'd1, 0, 0);
    n_checks++;
    if (full[0] !== 1'b0) begin
      n_fail++; $display("FAIL fill_one_full: got %b expected 0", full[0]);
    end
    step(1, 0, 4'hB, 3'd2, 0, 0);
    n_checks++;
    if (full[0] !== 1'b1) begin
      n_fail++; $display("FAIL fill_two_full: got %b expected 1", full[0]);
    end
    n_checks++;
    if (destport_o !== exp_dp() || destport_o[3:0] !== 4'hA) begin
      n_fail++; $display("FAIL fill_head: got %h expected %h", destport_o, exp_dp());
    end
    step(0, 0, '0, '0, 1, 0);
    n_checks++;
    if (destport_o !== exp_dp() || dest_e_addr_o !== exp_ea() || destport_o[3:0] !== 4'hB) begin
      n_fail++; $display("FAIL drain_head: got %h/%h expected %h/%h",
                         destport_o, dest_e_addr_o, exp_dp(), exp_ea());
    end
    n_checks++;
    if (full[0] !== 1'b0 || route_valid[0] !== 1'b1) begin
      n_fail++; $display("FAIL drain_flags: got full=%b rv=%b expected 0/1", full[0], route_valid[0]);
    end
    step(0, 0, '0, '0, 1, 0);
    n_checks++;
    if (route_valid !== exp_valid() || route_valid[0] !== 1'b0 || destport_o !== '0) begin
      n_fail++; $display("FAIL drain_empty: got rv=%b dp=%h expected rv=0 dp=0", route_valid, destport_o);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b0);
    step(1, 1, 4'h1, 3'd1, 0, 0);
    step(1, 1, 4'h2, 3'd2, 0, 0);
    step(1, 1, 4'h3, 3'd3, 1, 1);
    n_checks++;
    if (destport_o[7:4] !== 4'h2 || dest_e_addr_o !== exp_ea()) begin
      n_fail++; $display("FAIL b2b_head: got %h expected 2", destport_o[7:4]);
    end
    n_checks++;
    if (full[1] !== 1'b1 || err !== 1'b0) begin
      n_fail++; $display("FAIL b2b_full_err: got full=%b err=%b expected 1/0", full[1], err);
    end
    step(0, 0, '0, '0, 1, 1);
    n_checks++;
    if (destport_o[7:4] !== 4'h3 || destport_o !== exp_dp() || full[1] !== 1'b0) begin
      n_fail++; $display("FAIL b2b_next: got %h full=%b expected 3 full=0", destport_o[7:4], full[1]);
    end
  endtask

  task automatic test_errors();
    do_reset(1'b0);
    step(1, 3, 4'h4, 3'd4, 0, 0);
    step(1, 3, 4'h5, 3'd5, 0, 0);
    step(1, 3, 4'h6, 3'd6, 0, 0);
    n_checks++;
    if (err !== 1'b1 || err !== m_err) begin
      n_fail++; $display("FAIL ovf_err: got %b expected 1", err);
    end
    n_checks++;
    if (destport_o !== exp_dp() || full !== exp_full()) begin
      n_fail++; $display("FAIL ovf_state: got %h/%b expected %h/%b", destport_o, full, exp_dp(), exp_full());
    end
    step(0, 0, '0, '0, 1, 3);
    n_checks++;
    if (destport_o[15:12] !== 4'h5 || dest_e_addr_o !== exp_ea()) begin
      n_fail++; $display("FAIL ovf_second: got %h expected 5", destport_o[15:12]);
    end
    step(0, 0, '0, '0, 1, 3);
    n_checks++;
    if (route_valid[3] !== 1'b0) begin
      n_fail++; $display("FAIL ovf_drop: got rv3=%b expected 0", route_valid[3]);
    end
    do_reset(1'b0);
    step(0, 0, '0, '0, 1, 0);
    n_checks++;
    if (err !== 1'b1 || route_valid !== '0) begin
      n_fail++; $display("FAIL empty_pop: got err=%b rv=%b expected 1/0", err, route_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    step(1, 0, 4'h7, 3'd1, 0, 0);
    step(1, 0, 4'h8, 3'd2, 0, 0);
    do_reset(1'b1);
    n_checks++;
    if (route_valid !== '0 || full !== '0 || destport_o !== '0 || dest_e_addr_o !== '0 || err !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: got rv=%b full=%b dp=%h ea=%h err=%b expected all 0",
                         route_valid, full, destport_o, dest_e_addr_o, err);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (route_valid !== '0) begin
      n_fail++; $display("FAIL mid_reset_push: got rv=%b expected 0", route_valid);
    end
  endtask

  task automatic test_bypass();
    logic exp_same;
`ifdef LK_ROUTE_BYPASS_EN
    exp_same = 1'b1;
`else
    exp_same = 1'b0;
`endif
    do_reset(1'b0);
    wr_en          = 1'b1;
    wr_vc_num      = 4'b0010;
    wr_destport    = 4'b0011;
    wr_dest_e_addr = 3'd5;
    #1;
    n_checks++;
    if (route_valid[1] !== exp_same || destport_o[7:4] !== (exp_same ? 4'b0011 : 4'b0000)) begin
      n_fail++; $display("FAIL bypass_same: got rv=%b dp=%h expected rv=%b", route_valid[1], destport_o[7:4], exp_same);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    mq[1].push_back({4'b0011, 3'd5});
    n_checks++;
    if (route_valid !== exp_valid() || destport_o !== exp_dp() || dest_e_addr_o !== exp_ea()) begin
      n_fail++; $display("FAIL bypass_next: got rv=%b dp=%h ea=%h expected %b/%h/%h",
                         route_valid, destport_o, dest_e_addr_o, exp_valid(), exp_dp(), exp_ea());
    end
  endtask

  task automatic test_random();
    do_reset(1'b0);
    for (int c = 0; c < 300; c++) begin
      step($urandom_range(0, 1), $urandom_range(0, V-1), DSTPw'($urandom), EAw'($urandom),
           $urandom_range(0, 2) == 0, $urandom_range(0, V-1));
      n_checks++;
      if (route_valid !== exp_valid() || full !== exp_full()) begin
        n_fail++; $display("FAIL rand_flags[%0d]: got rv=%b full=%b expected %b/%b",
                           c, route_valid, full, exp_valid(), exp_full());
      end
      n_checks++;
      if (destport_o !== exp_dp() || dest_e_addr_o !== exp_ea()) begin
        n_fail++; $display("FAIL rand_data[%0d]: got %h/%h expected %h/%h",
                           c, destport_o, dest_e_addr_o, exp_dp(), exp_ea());
      end
      n_checks++;
      if (err !== m_err) begin
        n_fail++; $display("FAIL rand_err[%0d]: got %b expected %b", c, err, m_err);
      end
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    m_err = 1'b0;
    test_reset();
    test_single_push();
    test_fill_drain();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    test_bypass();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
